// File: rtl/fwd_select_unit.sv
// fwd_select_unit: registered ALU operand-forward selects plus load-use bubble.
// Optional FWD_STATS_EN adds stall_cycles / fwd_events counters.
module fwd_select_unit #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dmem_pending,
   input  logic             flush_id,
   input  logic [REG_W-1:0] rs_id,
   input  logic [REG_W-1:0] rt_id,
   input  logic             uses_rs_id,
   input  logic             uses_rt_id,
   input  logic [REG_W-1:0] rd_idex,
   input  logic             regwr_idex,
   input  logic             memread_idex,
   input  logic             lui_idex,
   input  logic [REG_W-1:0] rd_exmem,
   input  logic             regwr_exmem,
   output logic [1:0]       forwarda,
   output logic [1:0]       forwardb,
   output logic             stall_ifid,
   output logic             bubble_idex
`ifdef FWD_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] fwd_events
`endif
);

   typedef enum logic {
      RUN       = 1'b0,
      LU_BUBBLE = 1'b1
   } state_t;

   state_t state;

   logic       advance;
   logic       lu_rs;
   logic       lu_rt;
   logic       lu;
   logic [1:0] code_a;
   logic [1:0] code_b;
   logic [1:0] nxt_a;
   logic [1:0] nxt_b;

   // Select for one source: younger ID/EX writer wins over EX/MEM writer.
   function automatic logic [1:0] sel_code(
      input logic             used,
      input logic [REG_W-1:0] s,
      input logic [REG_W-1:0] rd_ex,
      input logic             wr_ex,
      input logic             ld_ex,
      input logic             lui_ex,
      input logic [REG_W-1:0] rd_mem,
      input logic             wr_mem
   );
      logic [1:0] c;
      c = 2'b00;
      if (used && (s != '0)) begin
         if (wr_ex && (rd_ex == s) && !ld_ex)
            c = lui_ex ? 2'b11 : 2'b01;
         else if (wr_mem && (rd_mem == s))
            c = 2'b10;
      end
      return c;
   endfunction

   assign advance = ihit & ~dmem_pending;

   // Load-use detection; only meaningful while not already inserting a bubble.
   always_comb begin
      lu_rs = uses_rs_id & (|rs_id) & regwr_idex & memread_idex
              & (rd_idex == rs_id);
      lu_rt = uses_rt_id & (|rt_id) & regwr_idex & memread_idex
              & (rd_idex == rt_id);
      lu    = (state == RUN) & (lu_rs | lu_rt) & ~flush_id;
   end

   assign stall_ifid  = lu;
   assign bubble_idex = lu;

   // Next-cycle selects: zeroed when a bubble or squashed op enters EX.
   always_comb begin
      code_a = sel_code(uses_rs_id, rs_id, rd_idex, regwr_idex,
                        memread_idex, lui_idex, rd_exmem, regwr_exmem);
      code_b = sel_code(uses_rt_id, rt_id, rd_idex, regwr_idex,
                        memread_idex, lui_idex, rd_exmem, regwr_exmem);
      nxt_a  = code_a;
      nxt_b  = code_b;
      if (flush_id || lu) begin
         nxt_a = 2'b00;
         nxt_b = 2'b00;
      end
   end

   // Capture selects and sequence the bubble at each pipeline advance.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= RUN;
         forwarda <= 2'b00;
         forwardb <= 2'b00;
      end else if (advance) begin
         forwarda <= nxt_a;
         forwardb <= nxt_b;
         state    <= lu ? LU_BUBBLE : RUN;
      end
   end

`ifdef FWD_STATS_EN
   logic [1:0] nz_cnt;

   assign nz_cnt = {1'b0, |nxt_a} + {1'b0, |nxt_b};

   // Wrapping counters of bubble advances and nonzero captured selects.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles <= '0;
         fwd_events   <= '0;
      end else if (advance) begin
         stall_cycles <= stall_cycles + CNT_W'(lu);
         fwd_events   <= fwd_events + CNT_W'(nz_cnt);
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// tb_fwd_select_unit: directed steps then random stimulus vs. reference model.
// Define FWD_STATS_EN to also check the statistics counters.
module tb_fwd_select_unit;

   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic             CLK = 1'b0;
   logic             RST;
   logic             ihit;
   logic             dmem_pending;
   logic             flush_id;
   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic             uses_rs_id;
   logic             uses_rt_id;
   logic [REG_W-1:0] rd_idex;
   logic             regwr_idex;
   logic             memread_idex;
   logic             lui_idex;
   logic [REG_W-1:0] rd_exmem;
   logic             regwr_exmem;
   logic [1:0]       forwarda;
   logic [1:0]       forwardb;
   logic             stall_ifid;
   logic             bubble_idex;
`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] fwd_events;
`endif

   int compared   = 0;
   int mismatched = 0;

   bit         m_bubble;
   logic [1:0] m_fa;
   logic [1:0] m_fb;
   int unsigned m_stalls;
   int unsigned m_fwd;
   logic       obs_stall;
   logic       obs_bubble;

   fwd_select_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ihit         (ihit),
      .dmem_pending (dmem_pending),
      .flush_id     (flush_id),
      .rs_id        (rs_id),
      .rt_id        (rt_id),
      .uses_rs_id   (uses_rs_id),
      .uses_rt_id   (uses_rt_id),
      .rd_idex      (rd_idex),
      .regwr_idex   (regwr_idex),
      .memread_idex (memread_idex),
      .lui_idex     (lui_idex),
      .rd_exmem     (rd_exmem),
      .regwr_exmem  (regwr_exmem),
      .forwarda     (forwarda),
      .forwardb     (forwardb),
      .stall_ifid   (stall_ifid),
      .bubble_idex  (bubble_idex)
`ifdef FWD_STATS_EN
      ,
      .stall_cycles (stall_cycles),
      .fwd_events   (fwd_events)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: which stage holds the newest value of register s.
   function automatic logic [1:0] ref_sel(input logic used,
                                          input logic [REG_W-1:0] s);
      if (!used || s == 0) return 2'b00;
      if (regwr_idex && rd_idex == s && !memread_idex)
         return lui_idex ? 2'b11 : 2'b01;
      if (regwr_exmem && rd_exmem == s) return 2'b10;
      return 2'b00;
   endfunction

   function automatic bit ref_needs_load(input logic used,
                                         input logic [REG_W-1:0] s);
      return used && s != 0 && regwr_idex && memread_idex && rd_idex == s;
   endfunction

   task automatic set_id(input logic ur, input int r, input logic ut,
                         input int t);
      uses_rs_id = ur; rs_id = REG_W'(r);
      uses_rt_id = ut; rt_id = REG_W'(t);
   endtask

   task automatic set_ex(input logic wr, input int rd, input logic ld,
                         input logic lui);
      regwr_idex = wr; rd_idex = REG_W'(rd);
      memread_idex = ld; lui_idex = lui;
   endtask

   task automatic set_mem(input logic wr, input int rd);
      regwr_exmem = wr; rd_exmem = REG_W'(rd);
   endtask

   // One clock: check hazard outputs before the edge, selects after it.
   task automatic step(input string tag);
      bit         lu;
      logic [1:0] ea;
      logic [1:0] eb;
      int         nz;
      #1;
      lu = !m_bubble && !flush_id &&
           (ref_needs_load(uses_rs_id, rs_id) ||
            ref_needs_load(uses_rt_id, rt_id));
      obs_stall  = stall_ifid;
      obs_bubble = bubble_idex;
      if (!RST) begin
         chk({tag, ".stall"}, 32'(stall_ifid), 32'(lu));
         chk({tag, ".bubble"}, 32'(bubble_idex), 32'(lu));
      end
      ea = ref_sel(uses_rs_id, rs_id);
      eb = ref_sel(uses_rt_id, rt_id);
      @(posedge CLK);
      #1;
      if (RST) begin
         m_bubble = 0; m_fa = 0; m_fb = 0; m_stalls = 0; m_fwd = 0;
      end else if (ihit && !dmem_pending) begin
         if (flush_id || lu) begin
            ea = 0; eb = 0;
         end
         m_fa = ea; m_fb = eb;
         m_bubble = lu;
         if (lu) m_stalls++;
         nz = (ea != 0 ? 1 : 0) + (eb != 0 ? 1 : 0);
         m_fwd += nz;
      end
      chk({tag, ".fa"}, 32'(forwarda), 32'(m_fa));
      chk({tag, ".fb"}, 32'(forwardb), 32'(m_fb));
`ifdef FWD_STATS_EN
      chk({tag, ".stalls"}, stall_cycles, m_stalls);
      chk({tag, ".fwdev"}, fwd_events, m_fwd);
`endif
      @(negedge CLK);
   endtask

   initial begin
      RST = 1; ihit = 0; dmem_pending = 0; flush_id = 0;
      set_id(0, 0, 0, 0); set_ex(0, 0, 0, 0); set_mem(0, 0);
      m_bubble = 0; m_fa = 0; m_fb = 0; m_stalls = 0; m_fwd = 0;
      @(negedge CLK);
      step("rst0");
      step("rst1");
      RST = 0;
      step("idle");
      chk("idle.fa0", 32'(forwarda), 0);
      chk("idle.stall0", 32'(obs_stall), 0);
      set_ex(1, 3, 0, 0); set_id(1, 3, 1, 3);
      step("hold");
      chk("hold.fa", 32'(forwarda), 0);
      ihit = 1;
      step("add3");
      chk("add3.fa", 32'(forwarda), 1);
      chk("add3.fb", 32'(forwardb), 1);
      set_ex(1, 3, 0, 1);
      step("lui3");
      chk("lui3.fa", 32'(forwarda), 3);
      chk("lui3.fb", 32'(forwardb), 3);
      set_ex(1, 5, 0, 0); set_mem(1, 5); set_id(0, 0, 1, 5);
      step("young");
      chk("young.fb", 32'(forwardb), 1);
      chk("young.fa", 32'(forwarda), 0);
      set_ex(0, 5, 0, 0);
      step("old");
      chk("old.fb", 32'(forwardb), 2);
      set_id(0, 0, 1, 0);
      step("r0");
      chk("r0.fb", 32'(forwardb), 0);
      // load-use
      set_ex(1, 7, 1, 0); set_mem(0, 0); set_id(1, 7, 0, 0);
      step("lu_n");
      chk("lu_n.stall", 32'(obs_stall), 1);
      chk("lu_n.bubble", 32'(obs_bubble), 1);
      chk("lu_n.fa", 32'(forwarda), 0);
      set_ex(0, 0, 0, 0); set_mem(1, 7);
      step("lu_n1");
      chk("lu_n1.stall", 32'(obs_stall), 0);
      chk("lu_n1.fa", 32'(forwarda), 2);
      // load-use while memory stalls
      set_ex(1, 7, 1, 0); set_mem(0, 0);
      dmem_pending = 1;
      for (int i = 0; i < 3; i++) begin
         step("dpend");
         chk("dpend.fa", 32'(forwarda), 2);
      end
      dmem_pending = 0;
      step("dgo");
      chk("dgo.fa", 32'(forwarda), 0);
      dmem_pending = 1;
      step("bub_pend");
      chk("bub_pend.stall", 32'(obs_stall), 0);
      dmem_pending = 0;
      set_ex(0, 0, 0, 0); set_mem(1, 7);
      step("bub_go");
      chk("bub_go.fa", 32'(forwarda), 2);
      // flushed load-use
      set_ex(1, 7, 1, 0); set_mem(1, 7); set_id(1, 7, 1, 7);
      flush_id = 1;
      step("flush");
      chk("flush.stall", 32'(obs_stall), 0);
      chk("flush.fa", 32'(forwarda), 0);
      chk("flush.fb", 32'(forwardb), 0);
      flush_id = 0;
      // reset in the middle of a bubble
      step("pre_rst");
      RST = 1;
      step("mid_rst");
      RST = 0;
      step("post_rst");
      chk("post_rst.stall", 32'(obs_stall), 1);
      // random phase
      for (int n = 0; n < 3000; n++) begin
         RST          = ($urandom_range(0, 99) == 0);
         ihit         = ($urandom_range(0, 3) != 0);
         dmem_pending = ($urandom_range(0, 3) == 0);
         flush_id     = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7));
         set_ex($urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
         set_mem($urandom_range(0, 1), $urandom_range(0, 7));
         step("rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/fwd_select_unit.md
Name: fwd_select_unit

Overview:
- Producer side of the EX-stage ALU operand forwarding interface.
- Computes the 2-bit forwarda/forwardb select codes one stage early, while the consumer instruction is in ID, and registers them at the ID/EX advance. They are valid while that instruction is in EX.
- Also detects load-use hazards and sequences the one-cycle bubble (IF/ID hold + ID/EX nop).
- Sits beside the ID/EX latch. Outputs drive the ALU A/B operand muxes and the hazard controls of the PC and IF/ID latches.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  synchronous reset, active-high.
- ihit  in  1  instruction fetch complete.
- dmem_pending  in  1  data access in MEM not yet complete (dhit outstanding); freezes the pipeline.
- flush_id  in  1  instruction in ID is squashed (taken branch/jump).
- rs_id  in  REG_W  rs of instruction in ID.
- rt_id  in  REG_W  rt of instruction in ID.
- uses_rs_id  in  1  ID instruction reads rs.
- uses_rt_id  in  1  ID instruction reads rt.
- rd_idex  in  REG_W  destination of instruction in ID/EX.
- regwr_idex  in  1  ID/EX instruction writes a register.
- memread_idex  in  1  ID/EX instruction is a load.
- lui_idex  in  1  ID/EX instruction is LUI (result on upper16 path).
- rd_exmem  in  REG_W  destination of instruction in EX/MEM.
- regwr_exmem  in  1  EX/MEM instruction writes a register.
- forwarda  out  2  registered A-operand select.
- forwardb  out  2  registered B-operand select.
- stall_ifid  out  1  hold PC and IF/ID this cycle.
- bubble_idex  out  1  load nop into ID/EX at this advance.

Behaviour:
- Select encoding, fixed by the operand muxes: 00 = register-file data; 01 = EX/MEM aluresult; 10 = writeback writedata; 11 = EX/MEM upper16.
- advance = ihit & ~dmem_pending. All registers update only when advance=1 or RST=1. Otherwise all state holds, including forwarda/forwardb and the FSM state.
- Per source s (rs, rt), for a used source with s != 0:
  - Code 11 if regwr_idex & rd_idex==s & ~memread_idex & lui_idex.
  - Else code 01 if regwr_idex & rd_idex==s & ~memread_idex.
  - Else code 10 if regwr_exmem & rd_exmem==s.
  - Else code 00.
- The ID/EX (younger) match has priority over the EX/MEM match.
- Register 0, or an unused source, always gives 00.
- A writer in MEM/WB while the consumer is in ID is not forwarded. The register file is write-through.
- Load-use hazard: lu = used s != 0 & regwr_idex & memread_idex & rd_idex==s (either source) & ~flush_id.
- FSM states RUN and LU_BUBBLE:
  - RUN: stall_ifid = bubble_idex = lu (combinational). On advance with lu, capture forwarda = forwardb = 00 (a bubble enters EX) and go to LU_BUBBLE. On advance without lu, capture the computed codes and stay in RUN.
  - LU_BUBBLE: stall_ifid = bubble_idex = 0. The load is now in EX/MEM, so the consumer's select resolves to 10. On advance, capture the codes and go to RUN.
- flush_id on advance: capture 00/00, state goes to RUN, lu is suppressed.
- dmem_pending during LU_BUBBLE: hold in LU_BUBBLE. stall_ifid stays 0 (the external freeze covers it).
- Reset values: forwarda = 00, forwardb = 00, state RUN, stall_ifid = 0, bubble_idex = 0. Reset mid-stall returns to RUN with no pending bubble.
- No combinational path from any input to forwarda/forwardb.

Optional Feature:
- Macro FWD_STATS_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0] and fwd_events[CNT_W-1:0].
  - stall_cycles increments on each advance taken with lu=1.
  - fwd_events increments by the number of nonzero codes (0–2) captured at each advance.
  - Both counters wrap modulo 2^CNT_W and clear on RST.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RST=1 for 2 cycles, then RST=0 with ihit=0 -> forwarda = forwardb = 00, stall_ifid = 0, outputs unchanged while ihit=0.
- ID/EX add $3 (regwr, not load); ID uses rs=3, rt=3; advance -> forwarda = forwardb = 01. Same stimulus with lui_idex=1 -> 11/11.
- ID/EX writes $5 (not load) and EX/MEM writes $5; ID uses rt=5 -> forwardb = 01 (younger wins). With regwr_idex=0 -> 10. With rt=0 -> 00.
- Load into $7 in ID/EX; ID uses rs=7:
  - Cycle n: stall_ifid = bubble_idex = 1; captured codes 00/00.
  - Cycle n+1 (LU_BUBBLE, rd_exmem=7): stall = 0; advance captures forwarda = 10.
- Load-use hazard present with dmem_pending=1 for 3 cycles -> state and codes hold. The transition to LU_BUBBLE occurs on the first cycle with dmem_pending=0 and ihit=1.
- Load-use hazard with flush_id=1 -> stall_ifid = 0, captured codes 00/00. With FWD_STATS_EN defined, stall_cycles is unchanged.
